param_memory_stage: RTL and testbench

PARAM_MEMORY_STAGE -- requirements
Module: param_memory_stage

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/byte_ram.sv | 27 ++
 rtl/param_memory_stage.sv | 167 ++++++++++++++++
 tb/tb_param_memory_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and helpers for the memory pipeline stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Wait counter must hold LATENCY-1; keep at least one bit for LATENCY=1.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - byte-addressed synchronous RAM, per-lane write enables, registered read
module byte_ram #(
    parameter int DEPTH = 1024,
    parameter int NB    = 2,
    parameter int AW    = 10
) (
    input  logic                clk,
    input  logic [NB-1:0]       we,
    input  logic [AW-1:0]       waddr,
    input  logic [NB-1:0][7:0]  wbytes,
    input  logic [AW-1:0]       raddr,
    output logic [NB-1:0][7:0]  q
);

    logic [7:0] mem [DEPTH];

    // Lane i maps to byte address base+i; the index wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[waddr + AW'(i)] <= wbytes[i];
            end
            q[i] <= mem[raddr + AW'(i)];
        end
    end

endmodule

// File: rtl/param_memory_stage.sv
// rtl/param_memory_stage.sv - data-memory pipeline stage with configurable access latency
module param_memory_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              branch,
    input  logic              zero,
    output logic              req_ready,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              pcsrc
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(NB);
    localparam int CW = cnt_width(LATENCY);

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic                op_write;
    logic                size_q;
    logic                sext_q;
    logic [AW-1:0]       addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                one_op;
    logic                misaligned;
    logic                accept;
    logic                reject;
    logic                finish;
    logic [NB-1:0]       ram_we;
    logic [NB-1:0][7:0]  ram_wbytes;
    logic [NB-1:0][7:0]  ram_q;
    logic [AW-1:0]       ram_raddr;
    logic [DATA_W-1:0]   rd_fmt;

    generate
        if (ADDR_W > AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:AW];
        end
    endgenerate

    assign one_op     = mem_read ^ mem_write;
    assign misaligned = (size == SIZE_WORD) && (addr[OW-1:0] != '0);
    assign accept     = (state == IDLE) && req_valid && one_op && !misaligned;
    assign reject     = (state == IDLE) && req_valid &&
                        ((mem_read && mem_write) || (one_op && misaligned));
    assign finish     = (state == BUSY) && (cnt == '0);

    assign req_ready  = (state == IDLE);
    assign stall      = (state != IDLE) || accept;
    assign pcsrc      = branch & zero;

    // Read address follows the live request in IDLE so data is registered by the acceptance edge.
    assign ram_raddr  = (state == IDLE) ? addr[AW-1:0] : addr_q;

    always_comb begin
        ram_we     = '0;
        ram_wbytes = '0;
        for (int i = 0; i < NB; i++) begin
            if (size_q == SIZE_WORD) begin
                ram_wbytes[i] = wdata_q[DATA_W-1-8*i -: 8];
            end else if (i == 0) begin
                ram_wbytes[i] = wdata_q[7:0];
            end
        end
        // Gating with rst_n keeps a reset on the completion edge from committing the write.
        if (finish && op_write && rst_n) begin
            ram_we = (size_q == SIZE_WORD) ? '1 : NB'(1);
        end
    end

    always_comb begin
        rd_fmt = '0;
        if (size_q == SIZE_WORD) begin
            for (int i = 0; i < NB; i++) begin
                rd_fmt[DATA_W-1-8*i -: 8] = ram_q[i];
            end
        end else begin
            rd_fmt = {{(DATA_W-8){sext_q & ram_q[0][7]}}, ram_q[0]};
        end
    end

    byte_ram #(
        .DEPTH (DEPTH),
        .NB    (NB),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (addr_q),
        .wbytes (ram_wbytes),
        .raddr  (ram_raddr),
        .q      (ram_q)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                end else if (reject) begin
                    state_nxt = RESP;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            err   <= reject;
            if (accept) begin
                cnt <= CW'(LATENCY - 1);
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (finish && !op_write) begin
                rdata <= rd_fmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= mem_write;
            size_q   <= size;
            sext_q   <= sign_ext;
            addr_q   <= addr[AW-1:0];
            wdata_q  <= wdata;
        end
    end

endmodule

// File: tb/tb_param_memory_stage.sv
// tb/tb_param_memory_stage.sv - scoreboard bench for param_memory_stage
module tb_param_memory_stage;

    localparam int DW    = 16;
    localparam int AWB   = 16;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;
    localparam int NB    = DW / 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           mem_read = 1'b0;
    logic           mem_write = 1'b0;
    logic           size = 1'b0;
    logic           sign_ext = 1'b0;
    logic [AWB-1:0] addr = '0;
    logic [DW-1:0]  wdata = '0;
    logic           branch = 1'b0;
    logic           zero = 1'b0;
    logic           req_ready;
    logic           stall;
    logic [DW-1:0]  rdata;
    logic           done;
    logic           err;
    logic           pcsrc;

    param_memory_stage #(
        .DATA_W  (DW),
        .ADDR_W  (AWB),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .branch    (branch),
        .zero      (zero),
        .req_ready (req_ready),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .pcsrc     (pcsrc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [7:0]    mem_m [DEPTH];
    logic [DW-1:0] rdata_m = '0;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int ai, input bit sz, input bit sx);
        logic [DW-1:0] v;
        v = '0;
        if (sz) begin
            for (int i = 0; i < NB; i++) v = (v << 8) | DW'(mem_m[(ai + i) % DEPTH]);
        end else begin
            v = DW'(mem_m[ai]);
            if (sx && mem_m[ai] >= 8'd128) v = v | ~DW'(255);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done || err)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got done=%0b err=%0b expected no response", done, err);
            end else begin
                e = sb.pop_front();
                chk("resp_is_err", 32'(err), 32'(e.is_err));
                chk("resp_rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input bit sz, input bit sx,
                         input logic [AWB-1:0] a, input logic [DW-1:0] wd);
        int  n;
        int  ai;
        bit  acc;
        bit  rej;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 32'(req_ready), 32'd1);
        ai  = int'(a) % DEPTH;
        acc = (rd ^ wr) && (!sz || (ai % NB) == 0);
        rej = (rd && wr) || ((rd ^ wr) && sz && (ai % NB) != 0);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        size = sz; sign_ext = sx; addr = a; wdata = wd;
        #1;
        chk("stall_on_issue", 32'(stall), 32'(acc));
        if (acc && wr) begin
            if (sz) begin
                for (int i = 0; i < NB; i++)
                    mem_m[(ai + i) % DEPTH] = 8'((wd >> (8 * (NB - 1 - i))) & 'hFF);
            end else begin
                mem_m[ai] = wd[7:0];
            end
            sb.push_back('{1'b0, rdata_m});
        end else if (acc && rd) begin
            rdata_m = model_read(ai, sz, sx);
            sb.push_back('{1'b0, rdata_m});
        end else if (rej) begin
            sb.push_back('{1'b1, rdata_m});
        end
        @(posedge clk);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            end
            addr = AWB'($urandom); wdata = DW'($urandom); size = 1'($urandom);
            branch = 1'($urandom); zero = 1'($urandom);
            #1;
            chk("pcsrc", 32'(pcsrc), 32'(branch & zero));
            if (acc) begin
                chk("done_timing", 32'(done), 32'(k == LAT + 1));
                chk("stall_busy", 32'(stall), 32'(k <= LAT));
                chk("ready_busy", 32'(req_ready), 32'(k > LAT));
            end else if (rej) begin
                chk("err_timing", 32'(err), 32'(k == 1));
                chk("done_on_reject", 32'(done), 32'd0);
                chk("ready_reject", 32'(req_ready), 32'(k != 1));
            end else begin
                chk("ignored_ready", 32'(req_ready), 32'd1);
                chk("ignored_pulse", 32'({done, err}), 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit sz;
        logic [AWB-1:0] a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done_err", 32'({done, err}), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);

        for (int w = 0; w < DEPTH; w += NB) issue(0, 1, 1, 0, AWB'(w), DW'($urandom));

        issue(0, 1, 1, 0, 16'h0010, 16'hBEEF);
        issue(1, 0, 1, 0, 16'h0010, '0);
        chk("beef_word", 32'(rdata), 32'h0000BEEF);
        issue(1, 0, 0, 1, 16'h0011, '0);
        chk("byte_sext", 32'(rdata), 32'h0000FFEF);
        issue(1, 0, 0, 0, 16'h0010, '0);
        chk("byte_zext", 32'(rdata), 32'h000000BE);

        issue(0, 1, 1, 0, 16'h0003, 16'h1111);
        issue(1, 1, 1, 0, 16'h0004, 16'h2222);
        issue(1, 0, 1, 0, 16'h0004, '0);
        issue(1, 0, 1, 0, 16'h0002, '0);
        issue(0, 0, 1, 0, 16'h0004, 16'h3333);

        issue(0, 1, 0, 0, 16'h0400, 16'h005A);
        issue(1, 0, 0, 1, 16'h0000, '0);
        chk("wrap_byte", 32'(rdata), 32'h0000005A);

        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        size = 1'b1; sign_ext = 1'b0; addr = 16'h0020; wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rdata_m = '0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_done_err", 32'({done, err}), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        repeat (LAT + 2) @(negedge clk);
        #1;
        issue(1, 0, 1, 0, 16'h0020, '0);

        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 9);
            sz = 1'($urandom);
            a  = AWB'($urandom);
            if (sz && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            issue(r <= 3 || r == 8, (r >= 4 && r <= 7) || r == 8, sz, 1'($urandom), a, DW'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
